// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and the {ERR, C, N, Z} flag layout.
package alu_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_AND = 3'd0,
      OP_OR  = 3'd1,
      OP_XOR = 3'd2,
      OP_ADD = 3'd3,
      OP_SUB = 3'd4
   } alu_op_e;

   localparam int FLAG_Z   = 0;
   localparam int FLAG_N   = 1;
   localparam int FLAG_C   = 2;
   localparam int FLAG_ERR = 3;

   typedef struct packed {
      logic err;
      logic c;
      logic n;
      logic z;
   } alu_flags_t;

endpackage

// File: rtl/alu_skid_buffer.sv
// Two-entry skid buffer: main entry drives the outputs, the skid entry absorbs one extra
// word so up_ready can be a register with no path from dn_ready.
module alu_skid_buffer #(
   parameter int DW = 36
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          up_valid,
   output logic          up_ready,
   input  logic [DW-1:0] up_data,
   output logic          dn_valid,
   input  logic          dn_ready,
   output logic [DW-1:0] dn_data
);

   logic          main_valid, skid_valid, skid_next, rdy;
   logic [DW-1:0] main_data, skid_data;
   logic          take, give;

   assign take     = up_valid & rdy;
   assign give     = main_valid & dn_ready;
   assign up_ready = rdy;
   assign dn_valid = main_valid;
   assign dn_data  = main_data;

   always_comb begin
      skid_next = skid_valid;
      if (main_valid && give && skid_valid && !take)
         skid_next = 1'b0;
      else if (main_valid && !give && take)
         skid_next = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         rdy        <= 1'b0;
         main_data  <= '0;
         skid_data  <= '0;
      end else begin
         rdy        <= !skid_next;
         skid_valid <= skid_next;
         if (!main_valid) begin
            if (take) begin
               main_valid <= 1'b1;
               main_data  <= up_data;
            end
         end else if (give) begin
            // Draining: oldest word first, the skid entry always precedes new input.
            if (skid_valid) begin
               main_data <= skid_data;
               if (take) skid_data <= up_data;
            end else if (take) begin
               main_data <= up_data;
            end else begin
               main_valid <= 1'b0;
            end
         end else if (take) begin
            skid_data <= up_data;
         end
      end
   end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: opcode-selected unit result plus Z/N/C/ERR flags, registered through a
// two-entry skid buffer with valid/ready on both sides.
module alu_result_stage #(
   parameter int WIDTH = 32,
   parameter int OP_W  = alu_pkg::OP_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [OP_W-1:0]  i_op,
   input  logic [WIDTH-1:0] i_and,
   input  logic [WIDTH-1:0] i_or,
   input  logic [WIDTH-1:0] i_xor,
   input  logic [WIDTH-1:0] i_sum,
   input  logic             i_carry,
   output logic             o_and_enable,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_result,
   output logic [3:0]       o_flags
);

   import alu_pkg::*;

   logic [WIDTH-1:0] result;
   alu_flags_t       flags;

   assign o_and_enable = i_valid & (i_op == OP_AND);

   always_comb begin
      result = '0;
      flags  = '0;
      case (i_op)
         OP_AND: result = i_and;
         OP_OR:  result = i_or;
         OP_XOR: result = i_xor;
         OP_ADD, OP_SUB: begin
            result  = i_sum;
            flags.c = i_carry;
         end
         default: flags.err = 1'b1;
      endcase
      flags.z = (result == '0);
      flags.n = result[WIDTH-1];
   end

   alu_skid_buffer #(.DW(WIDTH + 4)) u_buf (
      .clk      (clk),
      .rst      (rst),
      .up_valid (i_valid),
      .up_ready (o_ready),
      .up_data  ({flags, result}),
      .dn_valid (o_valid),
      .dn_ready (i_ready),
      .dn_data  ({o_flags, o_result})
   );

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed vectors with literal expectations plus a queue model
// checked against the outputs on every falling edge.
module tb_alu_result_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid, o_ready, i_carry, o_and_enable, o_valid, i_ready;
   logic [2:0]  i_op;
   logic [31:0] i_and, i_or, i_xor, i_sum, o_result;
   logic [3:0]  o_flags;

   int n_cmp = 0;
   int n_bad = 0;

   logic [35:0] q[$];
   logic        armed = 1'b0;

   always #5 clk = ~clk;

   alu_result_stage #(.WIDTH(32), .OP_W(3)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op),
      .i_and(i_and), .i_or(i_or), .i_xor(i_xor), .i_sum(i_sum), .i_carry(i_carry),
      .o_and_enable(o_and_enable), .o_valid(o_valid), .i_ready(i_ready),
      .o_result(o_result), .o_flags(o_flags)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected {ERR, C, N, Z, result} straight from the opcode rules.
   function automatic logic [35:0] expect_of(int op, logic [31:0] a, logic [31:0] o,
                                             logic [31:0] x, logic [31:0] s, logic c);
      logic [31:0] r  = 32'd0;
      logic        e  = 1'b0;
      logic        cy = 1'b0;
      if (op == 0)                r = a;
      else if (op == 1)           r = o;
      else if (op == 2)           r = x;
      else if (op == 3 || op == 4) begin r = s; cy = c; end
      else                        e = 1'b1;
      return {e, cy, r[31], r == 32'd0, r};
   endfunction

   // Model: FIFO of at most two words; ready whenever fewer than two held.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         armed <= 1'b0;
      end else begin
         bit acc_in, acc_out;
         acc_in  = i_valid && armed && q.size() < 2;
         acc_out = q.size() != 0 && i_ready;
         if (acc_out) void'(q.pop_front());
         if (acc_in) q.push_back(expect_of(int'(i_op), i_and, i_or, i_xor, i_sum, i_carry));
         armed <= 1'b1;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
         chk("rst_o_ready", {31'd0, o_ready}, 32'd0);
      end else begin
         chk("o_valid", {31'd0, o_valid}, {31'd0, q.size() != 0});
         chk("o_ready", {31'd0, o_ready}, {31'd0, armed && q.size() < 2});
         chk("o_and_enable", {31'd0, o_and_enable}, {31'd0, i_valid && i_op == 3'd0});
         if (q.size() != 0) begin
            chk("o_result", o_result, q[0][31:0]);
            chk("o_flags", {28'd0, o_flags}, {28'd0, q[0][35:32]});
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] o,
                        input logic [31:0] x, input logic [31:0] s, input logic c);
      i_valid = 1'b1; i_op = op; i_and = a; i_or = o; i_xor = x; i_sum = s; i_carry = c;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, cyc;
      rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_op = 3'd0;
      i_and = '0; i_or = '0; i_xor = '0; i_sum = '0; i_carry = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      tick;
      chk("reset_valid", {31'd0, o_valid}, 32'd0);
      chk("reset_result", o_result, 32'd0);
      chk("reset_flags", {28'd0, o_flags}, 32'd0);
      chk("reset_ready", {31'd0, o_ready}, 32'd1);

      // AND select and the enable pulse
      i_ready = 1'b1;
      drive(3'd0, 32'h0000_00F0, 32'hFFFF_FFFF, 32'h1111_1111, 32'h2222_2222, 1'b1);
      #1 chk("and_enable_issue", {31'd0, o_and_enable}, 32'd1);
      tick;
      i_valid = 1'b0; i_op = 3'd1;
      #1 chk("and_enable_after", {31'd0, o_and_enable}, 32'd0);
      chk("and_result", o_result, 32'h0000_00F0);
      chk("and_flags", {28'd0, o_flags}, 32'h0);

      drive(3'd4, 32'h5, 32'h6, 32'h7, 32'h0, 1'b1);
      tick;
      chk("sub_zero_result", o_result, 32'h0);
      chk("sub_zero_flags", {28'd0, o_flags}, 32'h5);
      drive(3'd3, 32'h5, 32'h6, 32'h7, 32'h8000_0000, 1'b0);
      tick;
      chk("add_neg_result", o_result, 32'h8000_0000);
      chk("add_neg_flags", {28'd0, o_flags}, 32'h2);

      drive(3'd7, 32'hA, 32'hB, 32'hC, 32'hD, 1'b1);
      tick;
      i_valid = 1'b0;
      chk("illegal_result", o_result, 32'h0);
      chk("illegal_flags", {28'd0, o_flags}, 32'h9);
      tick;

      // Backpressure: A held, B parked in skid, then both drain in order
      i_ready = 1'b0;
      drive(3'd2, 32'h0, 32'h0, 32'h0000_1234, 32'h0, 1'b0);
      tick;
      drive(3'd1, 32'h0, 32'h0000_AA55, 32'h0, 32'h0, 1'b0);
      tick;
      i_valid = 1'b0;
      chk("bp_ready_low", {31'd0, o_ready}, 32'd0);
      chk("bp_hold_a", o_result, 32'h0000_1234);
      tick;
      chk("bp_hold_a_again", o_result, 32'h0000_1234);
      i_ready = 1'b1;
      #1 chk("bp_deliver_a", o_result, 32'h0000_1234);
      tick;
      chk("bp_deliver_b", o_result, 32'h0000_AA55);
      chk("bp_ready_back", {31'd0, o_ready}, 32'd1);
      tick;
      chk("bp_empty", {31'd0, o_valid}, 32'd0);

      // Random traffic against the model
      acc = 0; cyc = 0;
      while (acc < 10000 && cyc < 60000) begin
         i_valid = ($urandom_range(0, 3) != 0);
         i_op    = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7))
                                               : 3'($urandom_range(0, 4));
         i_and   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         i_or    = $urandom;
         i_xor   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         i_sum   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         i_carry = 1'($urandom_range(0, 1));
         i_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (i_valid && o_ready) acc++;
         tick;
         cyc++;
      end
      chk("random_ops_accepted", acc, 32'd10000);
      i_valid = 1'b0; i_ready = 1'b1;
      repeat (3) tick;
      chk("drained", {31'd0, o_valid}, 32'd0);

      // Reset with both entries occupied
      i_ready = 1'b0;
      drive(3'd3, 32'h0, 32'h0, 32'h0, 32'h0000_0042, 1'b1);
      tick;
      drive(3'd2, 32'h0, 32'h0, 32'h0000_0099, 32'h0, 1'b0);
      tick;
      i_valid = 1'b0;
      chk("full_ready_low", {31'd0, o_ready}, 32'd0);
      chk("full_valid", {31'd0, o_valid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_valid", {31'd0, o_valid}, 32'd0);
      chk("midrst_result", o_result, 32'd0);
      chk("midrst_ready", {31'd0, o_ready}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      i_ready = 1'b1;
      repeat (4) tick;
      chk("post_rst_valid", {31'd0, o_valid}, 32'd0);
      chk("post_rst_ready", {31'd0, o_ready}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
